imp_arbitru: RTL and testbench
==============================

# imp_arbitru

Round-robin arbiter and sequencer that shares one sequential restoring divider among NREQ requesters. It latches the winning requester's operands and launches the divider with a one-cycle start pulse. It then waits for the divider's done, returns quotient and remainder with a one-cycle ack to the winner, and moves to the next request. Divide-by-zero is resolved locally without using the divider, and a watchdog covers a divider that never answers.

## Interface
- WIDTH, 4, operand/result width; must match the divider's WIDTH.
- NREQ, 4, number of requesters, 2..8.
- TIMEOUT, 64, maximum WAIT cycles before a timeout response.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NREQ  per-requester request level.
- a_in  in  NREQ*WIDTH  dividends; requester k uses bits [k*WIDTH +: WIDTH].
- b_in  in  NREQ*WIDTH  divisors, same packing.
- ack  out  NREQ  one-hot, one-cycle completion pulse.
- q_out  out  WIDTH  quotient of the last completed job.
- r_out  out  WIDTH  remainder of the last completed job.
- dbz_out  out  1  last job had divisor zero.
- tmo_out  out  1  last job timed out.
- busy  out  1  high in any state except IDLE.
- div_start  out  1  divider start pulse.
- div_a, div_b  out  WIDTH  divider operands.
- div_done  in  1  divider completion.
- div_q, div_r  in  WIDTH  divider results.

## Operation
- Reset values: state IDLE, rr pointer 0, ack 0, q_out 0, r_out 0, dbz_out 0, tmo_out 0, busy 0, div_start 0, div_a 0, div_b 0, watchdog 0.
- IDLE: if no req, stay in IDLE. Otherwise grant the first k with req[k]=1, searching from the rr pointer upward modulo NREQ. Latch k, a_in[k] and b_in[k]; set the pointer to (k+1) mod NREQ.
- From IDLE on a grant:
  - divisor 0: go to RESP with q=all ones, r=dividend, dbz=1, tmo=0;
  - otherwise: go to LAUNCH.
- LAUNCH (1 cycle): div_start=1; div_a and div_b are driven from the latched operands and held until RESP ends. div_done is ignored in this state. Next state is WAIT.
- WAIT: the watchdog increments every cycle.
  - div_done=1: capture div_q/div_r, dbz=0, tmo=0, go to RESP.
  - Watchdog reaches TIMEOUT-1 without done: q=0, r=0, tmo=1, go to RESP.
  - div_done and timeout in the same cycle: done wins.
- RESP (1 cycle): ack[k]=1. q_out, r_out, dbz_out and tmo_out update on entry to RESP and hold until the next RESP. Next state is IDLE; the watchdog clears.
- Requester rules:
  - Hold req high and operands stable until it samples ack=1.
  - Clear req on that same edge.
  - A req dropped before its ack is undefined use; the arbiter still completes the job and pulses ack.
- Requests arriving while busy wait in line; they are never lost.
- With all requesters continuously busy, each is granted at most once per NREQ jobs.

## Timing
- Normal job: grant edge → LAUNCH (1 cycle) → WAIT (D cycles, where D is the divider latency after start; D=WIDTH+1 for the standard divider) → RESP (1 cycle) → IDLE (1 cycle) before the next grant.
- Request-to-ack: if req rises in an IDLE cycle, ack is high D+2 cycles after the grant edge.
- Divide-by-zero: ack is high in the cycle after the grant edge.
- Minimum spacing between back-to-back jobs: D+3 cycles.
- All outputs are registered; there are no combinational paths from req or div_done to any output.
- Reset mid-operation: asynchronous return to the reset values. The in-flight job is dropped with no ack. div_start deasserts immediately, and the divider must also be reset.

## Test plan
- Single job, WIDTH=4, D=5 divider model: req[0], a=13, b=3 → div_start pulses once, ack[0] 7 cycles after the grant edge, q_out=4, r_out=1, dbz_out=0.
- Simultaneous req=4'b1111 held until each ack, all a=15, b=2 → ack order 0,1,2,3; then re-request all → order continues 0,1,2,3 from pointer 0; each q_out=7, r_out=1.
- Pointer wrap: after a job for requester 2, assert req[1] and req[3] together → requester 3 is granted first, then requester 1.
- Divide-by-zero: req[1], a=9, b=0 → no div_start, ack[1] in the cycle after the grant edge, q_out=4'hF, r_out=9, dbz_out=1.
- Timeout: divider model never raises done, TIMEOUT=64 → ack after 64 WAIT cycles, tmo_out=1, q_out=0, r_out=0; the next job then completes normally with tmo_out=0.
- Reset mid-WAIT: pull rst_n low for 1 cycle during WAIT → busy=0 and ack never pulses. Requests still held after reset release restart from pointer 0.

Source files
------------

// File: rtl/imp_arbitru.sv
// Round-robin front end that shares one sequential divider among NREQ requesters.
// Divide-by-zero is answered locally; a watchdog bounds the wait for the divider.
module imp_arbitru #(
  parameter int WIDTH   = 4,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q_out,
  output logic [WIDTH-1:0]      r_out,
  output logic                  dbz_out,
  output logic                  tmo_out,
  output logic                  busy,
  output logic                  div_start,
  output logic [WIDTH-1:0]      div_a,
  output logic [WIDTH-1:0]      div_b,
  input  logic                  div_done,
  input  logic [WIDTH-1:0]      div_q,
  input  logic [WIDTH-1:0]      div_r
);

  localparam int IW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic              dbz_q, dbz_d;
  logic              tmo_q, tmo_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;
  logic [WIDTH-1:0]  diva_q, diva_d;
  logic [WIDTH-1:0]  divb_q, divb_d;
  logic [WW-1:0]     wdog_q, wdog_d;

  logic [IW:0]       pick_s;
  logic [IW-1:0]     pick_idx_s;
  logic              pick_hit_s;
  logic [WIDTH-1:0]  a_sel_s;
  logic [WIDTH-1:0]  b_sel_s;

  // First requester at or after the pointer, wrapping modulo NREQ; MSB flags a hit.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] p);
    logic          found;
    logic          hit;
    logic [IW-1:0] idx;
    int            j;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      j     = (int'(p) + i) % NREQ;
      hit   = !found && r[j];
      idx   = hit ? IW'(j) : idx;
      found = found | r[j];
    end
    return {found, idx};
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] idx);
    return IW'((int'(idx) + 1) % NREQ);
  endfunction

  assign pick_s     = rr_pick(req, ptr_q);
  assign pick_hit_s = pick_s[IW];
  assign pick_idx_s = pick_s[IW-1:0];
  assign a_sel_s    = a_in[pick_idx_s*WIDTH +: WIDTH];
  assign b_sel_s    = b_in[pick_idx_s*WIDTH +: WIDTH];

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    tmo_d   = tmo_q;
    busy_d  = busy_q;
    start_d = 1'b0;
    diva_d  = diva_q;
    divb_d  = divb_q;
    wdog_d  = wdog_q;
    case (state_q)
      S_IDLE: begin
        if (pick_hit_s) begin
          gnt_d  = pick_idx_s;
          ptr_d  = ptr_after(pick_idx_s);
          busy_d = 1'b1;
          if (b_sel_s == '0) begin
            state_d = S_RESP;
            q_d     = '1;
            r_d     = a_sel_s;
            dbz_d   = 1'b1;
            tmo_d   = 1'b0;
            ack_d   = onehot(pick_idx_s);
          end else begin
            state_d = S_LAUNCH;
            start_d = 1'b1;
            diva_d  = a_sel_s;
            divb_d  = b_sel_s;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
        wdog_d  = '0;
      end
      S_WAIT: begin
        // done takes priority over an expiring watchdog in the same cycle
        if (div_done) begin
          state_d = S_RESP;
          q_d     = div_q;
          r_d     = div_r;
          dbz_d   = 1'b0;
          tmo_d   = 1'b0;
          ack_d   = onehot(gnt_q);
        end else if (wdog_q == WD_LAST) begin
          state_d = S_RESP;
          q_d     = '0;
          r_d     = '0;
          dbz_d   = 1'b0;
          tmo_d   = 1'b1;
          ack_d   = onehot(gnt_q);
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        wdog_d  = '0;
        diva_d  = '0;
        divb_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        wdog_d  = '0;
        diva_d  = '0;
        divb_d  = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      diva_q  <= '0;
      divb_q  <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      diva_q  <= diva_d;
      divb_q  <= divb_d;
      wdog_q  <= wdog_d;
    end
  end

  assign ack       = ack_q;
  assign q_out     = q_q;
  assign r_out     = r_q;
  assign dbz_out   = dbz_q;
  assign tmo_out   = tmo_q;
  assign busy      = busy_q;
  assign div_start = start_q;
  assign div_a     = diva_q;
  assign div_b     = divb_q;

endmodule

// File: tb/tb_imp_arbitru.sv
// Directed bench for imp_arbitru with a fixed-latency (D=5) divider model
// that can be told to hang so the watchdog path is exercised.
module tb_imp_arbitru;

  localparam int W = 4;
  localparam int N = 4;
  localparam int D = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   ack;
  logic [W-1:0]   q_out, r_out;
  logic           dbz_out, tmo_out, busy, div_start;
  logic [W-1:0]   div_a, div_b;
  logic           div_done;
  logic [W-1:0]   div_q, div_r;

  logic           hang;
  logic           dm_active;
  logic [3:0]     dm_cnt;
  logic [W-1:0]   dm_a, dm_b;

  int n_checks = 0;
  int n_errors = 0;

  imp_arbitru #(.WIDTH(W), .NREQ(N), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .ack(ack), .q_out(q_out), .r_out(r_out), .dbz_out(dbz_out), .tmo_out(tmo_out),
    .busy(busy), .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_q(div_q), .div_r(div_r)
  );

  always #5 clk = ~clk;

  // Divider model: done is sampled D edges after the edge that sampled start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_active <= 1'b0;
      dm_cnt    <= 4'd0;
      dm_a      <= '0;
      dm_b      <= '0;
      div_done  <= 1'b0;
      div_q     <= '0;
      div_r     <= '0;
    end else begin
      div_done <= 1'b0;
      if (div_start && !hang) begin
        dm_active <= 1'b1;
        dm_cnt    <= 4'(D - 1);
        dm_a      <= div_a;
        dm_b      <= div_b;
      end else if (dm_active) begin
        if (dm_cnt == 4'd1) begin
          div_done  <= 1'b1;
          div_q     <= dm_a / dm_b;
          div_r     <= dm_a % dm_b;
          dm_active <= 1'b0;
        end else begin
          dm_cnt <= dm_cnt - 4'd1;
        end
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[k*W +: W] = a;
    b_in[k*W +: W] = b;
  endtask

  task automatic wait_grant(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (busy === 1'b1) got = 1'b1;
    end
    check_val({tag, "_grant"}, 32'(got), 32'd1);
  endtask

  // Latency is counted in edges from the grant edge to the edge that samples ack.
  task automatic finish_job(input string tag, input logic [N-1:0] e_ack, input int e_lat,
                            input int e_starts, input logic [W-1:0] e_q, input logic [W-1:0] e_r,
                            input logic e_dbz, input logic e_tmo);
    int n;
    int starts;
    bit got;
    n = 0;
    starts = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      if (div_start === 1'b1) starts++;
      if (ack !== '0) got = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check_val({tag, "_ack_seen"}, 32'(got), 32'd1);
    check_val({tag, "_ack"}, 32'(ack), 32'(e_ack));
    check_val({tag, "_lat"}, 32'(n + 1), 32'(e_lat));
    check_val({tag, "_starts"}, 32'(starts), 32'(e_starts));
    check_val({tag, "_q"}, 32'(q_out), 32'(e_q));
    check_val({tag, "_r"}, 32'(r_out), 32'(e_r));
    check_val({tag, "_dbz"}, 32'(dbz_out), 32'(e_dbz));
    check_val({tag, "_tmo"}, 32'(tmo_out), 32'(e_tmo));
    req = req & ~ack;
  endtask

  task automatic run_job(input string tag, input logic [N-1:0] e_ack, input int e_lat,
                         input int e_starts, input logic [W-1:0] e_q, input logic [W-1:0] e_r,
                         input logic e_dbz, input logic e_tmo);
    wait_grant(tag);
    finish_job(tag, e_ack, e_lat, e_starts, e_q, e_r, e_dbz, e_tmo);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    hang  = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_ack", 32'(ack), 32'd0);
    check_val("rst_q", 32'(q_out), 32'd0);
    check_val("rst_r", 32'(r_out), 32'd0);
    check_val("rst_dbz", 32'(dbz_out), 32'd0);
    check_val("rst_tmo", 32'(tmo_out), 32'd0);
    check_val("rst_start", 32'(div_start), 32'd0);
    check_val("rst_div_a", 32'(div_a), 32'd0);
    check_val("rst_div_b", 32'(div_b), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("idle_busy", 32'(busy), 32'd0);

    // all four requesting: 15/2 = 7 r 1, order 0..3 twice
    for (int k = 0; k < N; k++) set_op(k, 4'd15, 4'd2);
    req = 4'b1111;
    for (int k = 0; k < N; k++)
      run_job($sformatf("rr1_%0d", k), 4'(1 << k), 7, 1, 4'd7, 4'd1, 1'b0, 1'b0);
    req = 4'b1111;
    for (int k = 0; k < N; k++)
      run_job($sformatf("rr2_%0d", k), 4'(1 << k), 7, 1, 4'd7, 4'd1, 1'b0, 1'b0);

    // single job 13/3 = 4 r 1
    set_op(0, 4'd13, 4'd3);
    req = 4'b0001;
    run_job("single", 4'b0001, 7, 1, 4'd4, 4'd1, 1'b0, 1'b0);

    // divide by zero answered locally
    set_op(1, 4'd9, 4'd0);
    req = 4'b0010;
    run_job("dbz", 4'b0010, 1, 0, 4'hF, 4'd9, 1'b1, 1'b0);

    // pointer wrap: after requester 2, requester 3 beats requester 1
    set_op(2, 4'd10, 4'd3);
    req = 4'b0100;
    run_job("wrap_a", 4'b0100, 7, 1, 4'd3, 4'd1, 1'b0, 1'b0);
    set_op(1, 4'd8, 4'd2);
    set_op(3, 4'd11, 4'd5);
    req = 4'b1010;
    run_job("wrap_b", 4'b1000, 7, 1, 4'd2, 4'd1, 1'b0, 1'b0);
    run_job("wrap_c", 4'b0010, 7, 1, 4'd4, 4'd0, 1'b0, 1'b0);

    // watchdog: 1 LAUNCH + 64 WAIT + 1 edge
    hang = 1'b1;
    set_op(0, 4'd6, 4'd2);
    req = 4'b0001;
    run_job("tmo", 4'b0001, 66, 1, 4'd0, 4'd0, 1'b0, 1'b1);
    hang = 1'b0;
    set_op(0, 4'd14, 4'd4);
    req = 4'b0001;
    run_job("post_tmo", 4'b0001, 7, 1, 4'd3, 4'd2, 1'b0, 1'b0);

    // reset during WAIT for requester 1; pointer must restart from 0
    set_op(1, 4'd7, 4'd3);
    set_op(3, 4'd9, 4'd4);
    req = 4'b1010;
    wait_grant("rstw");
    repeat (3) @(negedge clk);
    check_val("rstw_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("rstw_busy", 32'(busy), 32'd0);
    check_val("rstw_start", 32'(div_start), 32'd0);
    check_val("rstw_ack", 32'(ack), 32'd0);
    @(negedge clk);
    check_val("rstw_ack_hold", 32'(ack), 32'd0);
    rst_n = 1'b1;
    run_job("rstw_a", 4'b0010, 7, 1, 4'd2, 4'd1, 1'b0, 1'b0);
    run_job("rstw_b", 4'b1000, 7, 1, 4'd2, 4'd1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
